johnson_phase_decoder: RTL and testbench
========================================

# johnson_phase_decoder

Downstream consumer of the 32-bit Johnson counter. It samples the counter's code word each clock and checks that the word is a legal Johnson state. It decodes the word to a 6-bit phase index (0..63), checks that consecutive samples advance by exactly one phase, and counts full 64-phase revolutions. It sits between the Johnson counter output bus and the timing/sequencing logic that consumes phase and revolution events.

## Interface
- COUNT_W, 32, Johnson code width; fixed at 32 for this block (phase index is 6 bits).
- REV_W, 16, revolution counter width.

- Clk_In  input  1  clock; all state updates on rising edge.
- tb_Reset_In  input  1  reset, asynchronous, active-high.
- Enable_In  input  1  same enable that drives the counter's output tri-state; when 0 the code bus is Z and is not sampled.
- Counter_Count_In  input  32  Johnson code from counter.
- Clear_Stats_In  input  1  synchronous clear of revolution count and sticky errors.
- Phase_Valid_Out  output  1  Phase_Index_Out holds a legal decoded sample.
- Phase_Index_Out  output  6  decoded phase.
- Phase_Step_Out  output  1  one-cycle pulse: phase advanced by exactly +1 (mod 64).
- Revolution_Pulse_Out  output  1  one-cycle pulse on 63→0 step.
- Revolution_Count_Out  output  REV_W  revolutions since reset/clear, saturating.
- Illegal_Code_Out  output  1  sticky: a non-Johnson code was sampled.
- Skip_Error_Out  output  1  sticky: phase changed by anything other than 0 or +1.

## Operation
- Legal codes: thermometer from LSB (0x00000000, 0x00000001, 0x00000003 … 0xFFFFFFFF) and their left-shifted ones-fill (0xFFFFFFFE … 0x80000000); 64 codes total.
- Decode: if code[31]=0, index = popcount(code) (0..31); if code[31]=1, index = 32 + count of zeros (32..63). Examples: 0x00000001→1, 0xFFFFFFFF→32, 0x80000000→63.
- Stage 1, registered, when Enable_In=1:
  - Legal code: Phase_Index_Out ← index, Phase_Valid_Out ← 1.
  - Illegal code: Phase_Valid_Out ← 0, Phase_Index_Out holds, Illegal_Code_Out ← 1.
- Enable_In=0: Phase_Valid_Out ← 0, history invalidated; no errors or steps are generated.
- Stage 2 compares the new stage-1 sample with the previous one. It acts only when both samples are valid and consecutive (no invalid sample between them).
  - delta 0: hold, no pulse.
  - delta +1 mod 64: Phase_Step_Out pulse.
  - prev=63, new=0: additionally Revolution_Pulse_Out, and Revolution_Count_Out +1, saturating at 2^REV_W−1.
  - any other delta: Skip_Error_Out ← 1.
- First valid sample after reset, enable-off, or an illegal code is a reference only: no step and no error.
- Clear_Stats_In: Revolution_Count_Out ← 0, Illegal_Code_Out ← 0, Skip_Error_Out ← 0.
  - Clear has priority over a same-cycle increment or error set; that cycle's event is dropped from the sticky flags and the count.
  - Pulses still fire.

## Timing
- Reset values: Phase_Valid_Out=0, Phase_Index_Out=0, all pulses 0, Revolution_Count_Out=0, Illegal_Code_Out=0, Skip_Error_Out=0. Reset takes effect immediately, mid-stream included.
- Code sampled at edge N → Phase_Index_Out/Phase_Valid_Out/Illegal_Code_Out valid after edge N (1-cycle latency).
- Step/revolution pulses and Skip_Error_Out set after edge N+1 (2-cycle latency from code sample). Each pulse is high for exactly one cycle.
- Counter running continuously → Phase_Step_Out high every cycle; Revolution_Pulse_Out every 64 cycles.
- After reset release: first legal sample appears on outputs 1 cycle later; first possible step pulse 2 cycles later.

## Structure
- Package johnson_phase_pkg:
  - PHASE_W=6, NUM_PHASES=64, COUNT_W=32.
  - Pure function is_johnson_code.
  - Pure function johnson_to_phase.
- Sub-module johnson_code_to_phase: combinational legality check plus index decode. It is instantiated once ahead of stage 1.
- Top level holds the stage-1/stage-2 registers, the history-valid flag, the saturating revolution counter and the sticky flags.

## Test plan
- Reset then Enable_In=1, code 0x00000001 held → Phase_Valid_Out=1 and Phase_Index_Out=1 after 1 cycle; no pulses; both error flags 0.
- Codes 0x1, 0x3, 0x7, 0xF on consecutive cycles → indices 1, 2, 3, 4; Phase_Step_Out high for 3 consecutive cycles starting 2 cycles after 0x3.
- Full run through 0x80000000 → 0x00000000 → Revolution_Pulse_Out once; Revolution_Count_Out=1. Then assert Clear_Stats_In → count 0.
- Code 0x00000005 → Phase_Valid_Out=0 and Illegal_Code_Out=1, staying 1. Next legal code gives no Skip_Error_Out.
- Codes 0x3 then 0xF (2→4) → Skip_Error_Out=1. Alternatively, 0x3, then Enable_In=0 for 2 cycles, then 0xF → no Skip_Error_Out.
- Assert tb_Reset_In mid-run → all outputs at reset values immediately. Preset count to 2^16−1 and wrap again → count stays 0xFFFF.

Source files
------------

// File: rtl/johnson_phase_decoder_pkg.sv
// Shared constants and pure helpers for decoding the 32-bit Johnson counter
// code word into a 6-bit phase index.
package johnson_phase_pkg;

  localparam int PHASE_W    = 6;
  localparam int NUM_PHASES = 64;
  localparam int COUNT_W    = 32;

  // A legal word is a thermometer from the LSB, or the bitwise inverse of one
  // when the MSB is set (the ones-fill half of the Johnson cycle). Folding on
  // the MSB turns both halves into the same "2^k - 1" shape test.
  function automatic logic is_johnson_code(input logic [COUNT_W-1:0] code);
    logic [COUNT_W-1:0] folded;
    folded = code[COUNT_W-1] ? ~code : code;
    return ((folded & (folded + COUNT_W'(1))) == '0);
  endfunction

  // Phase is the count of ones in the first half (MSB clear) and 32 plus the
  // count of zeros in the second half (MSB set). XOR with the MSB makes both
  // cases a plain popcount. Only meaningful for legal codes.
  function automatic logic [PHASE_W-1:0] johnson_to_phase(input logic [COUNT_W-1:0] code);
    logic [COUNT_W-1:0] folded;
    logic [PHASE_W-1:0] ones;
    folded = code ^ {COUNT_W{code[COUNT_W-1]}};
    ones   = '0;
    for (int i = 0; i < COUNT_W; i++) begin
      ones = ones + PHASE_W'(folded[i]);
    end
    return code[COUNT_W-1] ? (PHASE_W'(NUM_PHASES / 2) + ones) : ones;
  endfunction

endpackage

// File: rtl/johnson_phase_decoder_code_to_phase.sv
// Combinational front end: flags whether the sampled word is a legal Johnson
// state and decodes it to a phase index.
module johnson_code_to_phase
  import johnson_phase_pkg::*;
(
  input  logic [COUNT_W-1:0] i_Code,
  output logic               o_Legal,
  output logic [PHASE_W-1:0] o_Index
);

  assign o_Legal = is_johnson_code(i_Code);
  assign o_Index = johnson_to_phase(i_Code);

endmodule

// File: rtl/johnson_phase_decoder.sv
// Samples the Johnson counter bus, decodes it to a phase index, checks that
// successive samples advance by one phase and counts full revolutions.
module johnson_phase_decoder
  import johnson_phase_pkg::*;
#(
  parameter int REV_W = 16
) (
  input  logic               Clk_In,
  input  logic               tb_Reset_In,
  input  logic               Enable_In,
  input  logic [COUNT_W-1:0] Counter_Count_In,
  input  logic               Clear_Stats_In,
  output logic               Phase_Valid_Out,
  output logic [PHASE_W-1:0] Phase_Index_Out,
  output logic               Phase_Step_Out,
  output logic               Revolution_Pulse_Out,
  output logic [REV_W-1:0]   Revolution_Count_Out,
  output logic               Illegal_Code_Out,
  output logic               Skip_Error_Out
);

  localparam logic [REV_W-1:0]   REV_MAX    = '1;
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  logic               w_legal;
  logic [PHASE_W-1:0] w_index;

  // Stage 1: the current decoded sample
  logic               r_phaseValid;
  logic [PHASE_W-1:0] r_phaseIndex;
  logic               r_illegal;

  // Stage 2: the previous sample plus the event outputs
  logic               r_histValid;
  logic [PHASE_W-1:0] r_histIndex;
  logic               r_step;
  logic               r_rev;
  logic [REV_W-1:0]   r_revCount;
  logic               r_skip;

  logic               w_compare;
  logic [PHASE_W-1:0] w_delta;
  logic               w_isStep;
  logic               w_isRev;
  logic               w_isSkip;

  johnson_code_to_phase u_decode (
    .i_Code  (Counter_Count_In),
    .o_Legal (w_legal),
    .o_Index (w_index)
  );

  // Register the decoded sample; illegal words and a disabled bus drop valid
  // while the last good index is held for downstream consumers.
  always_ff @(posedge Clk_In or posedge tb_Reset_In) begin
    if (tb_Reset_In) begin
      r_phaseValid <= 1'b0;
      r_phaseIndex <= '0;
      r_illegal    <= 1'b0;
    end else begin
      if (Enable_In && w_legal) begin
        r_phaseValid <= 1'b1;
        r_phaseIndex <= w_index;
      end else begin
        r_phaseValid <= 1'b0;
      end
      if (Clear_Stats_In) begin
        r_illegal <= 1'b0;
      end else if (Enable_In && !w_legal) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Only two back-to-back valid samples are compared, so the first sample
  // after any gap is a reference; the subtraction wraps mod 64 so 63->0 is +1.
  assign w_compare = r_phaseValid && r_histValid;
  assign w_delta   = r_phaseIndex - r_histIndex;
  assign w_isStep  = w_compare && (w_delta == PHASE_W'(1));
  assign w_isRev   = w_isStep && (r_histIndex == LAST_PHASE);
  assign w_isSkip  = w_compare && (w_delta != '0) && (w_delta != PHASE_W'(1));

  // Shift the sample history and raise step/revolution pulses for one cycle.
  always_ff @(posedge Clk_In or posedge tb_Reset_In) begin
    if (tb_Reset_In) begin
      r_histValid <= 1'b0;
      r_histIndex <= '0;
      r_step      <= 1'b0;
      r_rev       <= 1'b0;
    end else begin
      r_histValid <= r_phaseValid;
      r_histIndex <= r_phaseIndex;
      r_step      <= w_isStep;
      r_rev       <= w_isRev;
    end
  end

  // Statistics: clear wins over a same-cycle increment or error, and the
  // revolution count sticks at its maximum rather than wrapping.
  always_ff @(posedge Clk_In or posedge tb_Reset_In) begin
    if (tb_Reset_In) begin
      r_revCount <= '0;
      r_skip     <= 1'b0;
    end else if (Clear_Stats_In) begin
      r_revCount <= '0;
      r_skip     <= 1'b0;
    end else begin
      if (w_isRev && (r_revCount != REV_MAX)) begin
        r_revCount <= r_revCount + REV_W'(1);
      end
      if (w_isSkip) begin
        r_skip <= 1'b1;
      end
    end
  end

  assign Phase_Valid_Out      = r_phaseValid;
  assign Phase_Index_Out      = r_phaseIndex;
  assign Phase_Step_Out       = r_step;
  assign Revolution_Pulse_Out = r_rev;
  assign Revolution_Count_Out = r_revCount;
  assign Illegal_Code_Out     = r_illegal;
  assign Skip_Error_Out       = r_skip;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder. A second instance with a 3-bit
// revolution counter shares the stimulus so saturation is reachable quickly.
module tb_johnson_phase_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] countIn;
  logic        clearStats;

  logic        phaseValid;
  logic [5:0]  phaseIndex;
  logic        phaseStep;
  logic        revPulse;
  logic [15:0] revCount;
  logic        illegalCode;
  logic        skipError;

  logic        phaseValidSat;
  logic [5:0]  phaseIndexSat;
  logic        phaseStepSat;
  logic        revPulseSat;
  logic [2:0]  revCountSat;
  logic        illegalCodeSat;
  logic        skipErrorSat;

  int testsRun    = 0;
  int testsFailed = 0;

  johnson_phase_decoder dut (
    .Clk_In               (clk),
    .tb_Reset_In          (rst),
    .Enable_In            (enable),
    .Counter_Count_In     (countIn),
    .Clear_Stats_In       (clearStats),
    .Phase_Valid_Out      (phaseValid),
    .Phase_Index_Out      (phaseIndex),
    .Phase_Step_Out       (phaseStep),
    .Revolution_Pulse_Out (revPulse),
    .Revolution_Count_Out (revCount),
    .Illegal_Code_Out     (illegalCode),
    .Skip_Error_Out       (skipError)
  );

  johnson_phase_decoder #(.REV_W(3)) dutSat (
    .Clk_In               (clk),
    .tb_Reset_In          (rst),
    .Enable_In            (enable),
    .Counter_Count_In     (countIn),
    .Clear_Stats_In       (clearStats),
    .Phase_Valid_Out      (phaseValidSat),
    .Phase_Index_Out      (phaseIndexSat),
    .Phase_Step_Out       (phaseStepSat),
    .Revolution_Pulse_Out (revPulseSat),
    .Revolution_Count_Out (revCountSat),
    .Illegal_Code_Out     (illegalCodeSat),
    .Skip_Error_Out       (skipErrorSat)
  );

  always #5 clk = ~clk;

  // Johnson encoder: thermometer for phases 0..31, inverted thermometer above.
  function automatic logic [31:0] jcode(input int p);
    logic [31:0] t;
    if (p < 32) t = 32'((64'd1 << p) - 64'd1);
    else        t = ~32'((64'd1 << (p - 32)) - 64'd1);
    return t;
  endfunction

  // Drive one cycle of inputs, then return 1 time unit after the edge. A
  // disabled bus carries an illegal word to prove it is not sampled.
  task automatic applyStimulus(input logic en, input logic [31:0] code, input logic clr);
    enable     = en;
    countIn    = en ? code : 32'h0000_0005;
    clearStats = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; countIn = 32'h0; clearStats = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    testsRun++;
    if ({phaseValid, phaseIndex, phaseStep, revPulse, revCount, illegalCode, skipError} !== 28'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {phaseValid, phaseIndex, phaseStep, revPulse, revCount, illegalCode, skipError});
    end
    rst = 1'b0;
  endtask

  task automatic test_first_sample();
    applyStimulus(1'b1, 32'h0000_0001, 1'b0);
    testsRun++;
    if (phaseValid !== 1'b1) begin testsFailed++; $display("[TB] FAIL first_valid: got %b expected 1", phaseValid); end
    testsRun++;
    if (phaseIndex !== 6'd1) begin testsFailed++; $display("[TB] FAIL first_index: got %0d expected 1", phaseIndex); end
    testsRun++;
    if ({phaseStep, revPulse, illegalCode, skipError} !== 4'b0) begin
      testsFailed++; $display("[TB] FAIL first_flags: got %b expected 0000", {phaseStep, revPulse, illegalCode, skipError});
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h0000_0001, 1'b0);
      testsRun++;
      if ({phaseStep, skipError} !== 2'b00) begin
        testsFailed++; $display("[TB] FAIL hold_no_step[%0d]: got %b expected 00", i, {phaseStep, skipError});
      end
    end
  endtask

  task automatic test_steps();
    logic [31:0] codes [5]   = '{32'h3, 32'h7, 32'hF, 32'hF, 32'hF};
    int          expIdx [5]  = '{2, 3, 4, 4, 4};
    logic        expStep [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, codes[i], 1'b0);
      testsRun++;
      if (phaseIndex !== 6'(expIdx[i])) begin
        testsFailed++; $display("[TB] FAIL step_index[%0d]: got %0d expected %0d", i, phaseIndex, expIdx[i]);
      end
      testsRun++;
      if (phaseStep !== expStep[i]) begin
        testsFailed++; $display("[TB] FAIL step_pulse[%0d]: got %b expected %b", i, phaseStep, expStep[i]);
      end
    end
  endtask

  task automatic test_revolution();
    int p;
    int revSeen = 0;
    for (int k = 0; k < 62; k++) begin
      p = (k < 59) ? k + 5 : k - 59;
      applyStimulus(1'b1, jcode(p), 1'b0);
      revSeen += int'(revPulse);
      testsRun++;
      if (phaseIndex !== 6'(p)) begin
        testsFailed++; $display("[TB] FAIL rev_index[%0d]: got %0d expected %0d", k, phaseIndex, p);
      end
      testsRun++;
      if (phaseStep !== (k > 0)) begin
        testsFailed++; $display("[TB] FAIL rev_step[%0d]: got %b expected %b", k, phaseStep, (k > 0));
      end
      testsRun++;
      if (revPulse !== (p == 1)) begin
        testsFailed++; $display("[TB] FAIL rev_pulse[%0d]: got %b expected %b", k, revPulse, (p == 1));
      end
    end
    testsRun++;
    if (revSeen != 1) begin testsFailed++; $display("[TB] FAIL rev_pulse_total: got %0d expected 1", revSeen); end
    testsRun++;
    if (revCount !== 16'd1) begin testsFailed++; $display("[TB] FAIL rev_count: got %0d expected 1", revCount); end
    testsRun++;
    if ({illegalCode, skipError} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL rev_errors: got %b expected 00", {illegalCode, skipError});
    end
    applyStimulus(1'b1, jcode(3), 1'b1);
    testsRun++;
    if (revCount !== 16'd0) begin testsFailed++; $display("[TB] FAIL clear_count: got %0d expected 0", revCount); end
    testsRun++;
    if (phaseStep !== 1'b1) begin testsFailed++; $display("[TB] FAIL clear_step_fires: got %b expected 1", phaseStep); end
    applyStimulus(1'b1, jcode(4), 1'b0);
    testsRun++;
    if (revCount !== 16'd0) begin testsFailed++; $display("[TB] FAIL clear_count_stays: got %0d expected 0", revCount); end
  endtask

  task automatic test_clear_priority();
    applyStimulus(1'b1, 32'h0000_0005, 1'b1);
    testsRun++;
    if ({phaseValid, illegalCode} !== 2'b00) begin
      testsFailed++; $display("[TB] FAIL clear_vs_illegal: got %b expected 00", {phaseValid, illegalCode});
    end
    applyStimulus(1'b1, jcode(4), 1'b0);
    testsRun++;
    if ({phaseValid, illegalCode} !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL clear_vs_illegal_after: got %b expected 10", {phaseValid, illegalCode});
    end
  endtask

  task automatic test_illegal();
    int   seqIdx [4]  = '{10, 10, 11, 11};
    logic seqStep [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(1'b1, 32'h0000_0005, 1'b0);
    testsRun++;
    if ({phaseValid, illegalCode} !== 2'b01) begin
      testsFailed++; $display("[TB] FAIL illegal_detect: got %b expected 01", {phaseValid, illegalCode});
    end
    testsRun++;
    if (phaseIndex !== 6'd4) begin testsFailed++; $display("[TB] FAIL illegal_hold_index: got %0d expected 4", phaseIndex); end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, jcode(seqIdx[i]), 1'b0);
      testsRun++;
      if ({phaseIndex, phaseStep, illegalCode, skipError} !== {6'(seqIdx[i]), seqStep[i], 1'b1, 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL illegal_recover[%0d]: got idx=%0d step=%b ill=%b skip=%b expected idx=%0d step=%b ill=1 skip=0",
                 i, phaseIndex, phaseStep, illegalCode, skipError, seqIdx[i], seqStep[i]);
      end
    end
    applyStimulus(1'b1, jcode(11), 1'b1);
    testsRun++;
    if (illegalCode !== 1'b0) begin testsFailed++; $display("[TB] FAIL illegal_clear: got %b expected 0", illegalCode); end
  endtask

  task automatic test_enable_gap();
    logic        gapEn [8]    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] gapCode [8]  = '{32'h0, 32'h0, 32'h3, 32'h0, 32'h0, 32'hF, 32'hF, 32'hF};
    int          gapIdx [8]   = '{11, 11, 2, 2, 2, 4, 4, 4};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(gapEn[i], gapCode[i], 1'b0);
      testsRun++;
      if ({phaseValid, phaseIndex, phaseStep, illegalCode, skipError} !== {gapEn[i], 6'(gapIdx[i]), 3'b000}) begin
        testsFailed++;
        $display("[TB] FAIL enable_gap[%0d]: got v=%b idx=%0d step=%b ill=%b skip=%b expected v=%b idx=%0d step=0 ill=0 skip=0",
                 i, phaseValid, phaseIndex, phaseStep, illegalCode, skipError, gapEn[i], gapIdx[i]);
      end
    end
  endtask

  task automatic test_skip();
    logic        skEn [11]   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] skCode [11] = '{32'h0, 32'h3, 32'hF, 32'hF, 32'hF, 32'hF, 32'h0, 32'h3, 32'hF, 32'hF, 32'hF};
    logic        skClr [11]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        skExp [11]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(skEn[i], skCode[i], skClr[i]);
      testsRun++;
      if ({skipError, phaseStep} !== {skExp[i], 1'b0}) begin
        testsFailed++;
        $display("[TB] FAIL skip[%0d]: got skip=%b step=%b expected skip=%b step=0", i, skipError, phaseStep, skExp[i]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int runPhases [6] = '{60, 61, 62, 63, 0, 1};
    applyStimulus(1'b1, 32'h0000_0005, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, jcode(runPhases[i]), 1'b0);
    testsRun++;
    if ({phaseValid, phaseIndex, phaseStep, revPulse, revCount, illegalCode} !== {1'b1, 6'd1, 1'b1, 1'b1, 16'd1, 1'b1}) begin
      testsFailed++;
      $display("[TB] FAIL pre_reset_state: got v=%b idx=%0d step=%b rev=%b cnt=%0d ill=%b expected v=1 idx=1 step=1 rev=1 cnt=1 ill=1",
               phaseValid, phaseIndex, phaseStep, revPulse, revCount, illegalCode);
    end
    rst = 1'b1;
    #1;
    testsRun++;
    if ({phaseValid, phaseIndex, phaseStep, revPulse, revCount, illegalCode, skipError} !== 28'h0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset: got %h expected 0",
               {phaseValid, phaseIndex, phaseStep, revPulse, revCount, illegalCode, skipError});
    end
    testsRun++;
    if ({phaseValidSat, phaseIndexSat, phaseStepSat, revPulseSat, revCountSat, illegalCodeSat, skipErrorSat} !== 15'h0) begin
      testsFailed++;
      $display("[TB] FAIL midrun_reset_sat: got %h expected 0",
               {phaseValidSat, phaseIndexSat, phaseStepSat, revPulseSat, revCountSat, illegalCodeSat, skipErrorSat});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    int revSeenSat = 0;
    for (int r = 0; r < 9; r++) begin
      for (int p = 0; p < 64; p++) begin
        applyStimulus(1'b1, jcode(p), 1'b0);
        revSeenSat += int'(revPulseSat);
      end
    end
    applyStimulus(1'b1, jcode(0), 1'b0);
    revSeenSat += int'(revPulseSat);
    applyStimulus(1'b1, jcode(1), 1'b0);
    revSeenSat += int'(revPulseSat);
    testsRun++;
    if (revCount !== 16'd9) begin testsFailed++; $display("[TB] FAIL sat_main_count: got %0d expected 9", revCount); end
    testsRun++;
    if (revCountSat !== 3'd7) begin testsFailed++; $display("[TB] FAIL sat_count: got %0d expected 7", revCountSat); end
    testsRun++;
    if (revSeenSat != 9) begin testsFailed++; $display("[TB] FAIL sat_pulses: got %0d expected 9", revSeenSat); end
    testsRun++;
    if ({illegalCode, skipError, illegalCodeSat, skipErrorSat} !== 4'b0) begin
      testsFailed++;
      $display("[TB] FAIL sat_errors: got %b expected 0000", {illegalCode, skipError, illegalCodeSat, skipErrorSat});
    end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_steps();
    test_revolution();
    test_clear_priority();
    test_illegal();
    test_enable_gap();
    test_skip();
    test_reset_midrun();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
